cas_key_loader: RTL and testbench

- Provisioning end of the CAS-Lock key interface. It receives a key plus checksum serially from the secure key store over a valid/ready bit handshake, verifies the checksum, and drives the parallel keyinput bus that the locked netlist consumes.
- keyinput is updated only after a verified load. A failed load zeroizes it.
- Repeated failures lock the block out until reset.

---
 rtl/cas_key_pkg.sv | 19 +
 rtl/cas_key_chk.sv | 30 +++
 rtl/cas_key_loader.sv | 154 +++++++++++++++
 tb/tb_cas_key_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cas_key_pkg.sv
// Shared types and default widths for the CAS-Lock key loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: loader FSM state enum and the default key/checksum widths.
package cas_key_pkg;

  localparam int KEY_W_DEF = 64;
  localparam int CHK_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_DONE,
    ST_ERROR,
    ST_LOCKOUT
  } state_t;

endpackage

// File: rtl/cas_key_chk.sv
// Running-XOR checksum: folds each key bit into chk[idx].
// Latency: result reflects a folded bit one edge after en.
// Backpressure: none; the caller gates en with its own transfer condition.
// Ports: clk, rst_n, clr (sync clear), en (fold this cycle), bit_in, idx (target lane), chk (result).
module cas_key_chk
  import cas_key_pkg::*;
#(
  parameter int CHK_W = CHK_W_DEF,
  parameter int IW    = (CHK_W > 1) ? $clog2(CHK_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [IW-1:0]    idx,
  output logic [CHK_W-1:0] chk
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk <= '0;
    end else if (clr) begin
      chk <= '0;
    end else if (en) begin
      chk <= chk ^ (CHK_W'(bit_in) << idx);
    end
  end

endmodule

// File: rtl/cas_key_loader.sv
// Serial key load with checksum verify, drives keyinput of the locked netlist.
// Latency: last bit at edge T -> CHECK after T; keyinput/key_valid after T+1.
// Backpressure: s_ready high only in SHIFT; bits offered elsewhere stay unconsumed.
// Ports: load_start (pulse), s_valid/s_data/s_ready (serial bit handshake),
//        keyinput/key_valid (verified key), busy, err_chk, err_timeout, locked_out, fail_cnt.
module cas_key_loader
  import cas_key_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
  parameter int CHK_W    = CHK_W_DEF,
  parameter int MAX_FAIL = 3,
  parameter int TIMEOUT  = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_start,
  input  logic                          s_valid,
  input  logic                          s_data,
  output logic                          s_ready,
  output logic [KEY_W-1:0]              keyinput,
  output logic                          key_valid,
  output logic                          busy,
  output logic                          err_chk,
  output logic                          err_timeout,
  output logic                          locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

  localparam int FW      = $clog2(MAX_FAIL + 1);
  localparam int FRAME_W = KEY_W + CHK_W;
  localparam int BW      = $clog2(FRAME_W + 1);
  localparam int TW      = $clog2(TIMEOUT);
  localparam int IW      = (CHK_W > 1) ? $clog2(CHK_W) : 1;

  localparam logic [BW-1:0] KEY_END  = BW'(KEY_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);

  state_t            state, state_nxt;
  logic [BW-1:0]     bit_cnt;
  logic [KEY_W-1:0]  shadow;
  logic [CHK_W-1:0]  rx_chk;
  logic [CHK_W-1:0]  acc;
  logic [TW-1:0]     tmo_cnt;
  logic [TW-1:0]     tmo_nxt;
  logic [FW-1:0]     fail_inc;
  logic              take, start, tmo_hit, chk_ok, do_fail, do_pass;

  assign s_ready    = (state == ST_SHIFT);
  assign busy       = (state == ST_SHIFT) || (state == ST_CHECK);
  assign locked_out = (state == ST_LOCKOUT);
  assign take       = s_valid & s_ready;
  assign chk_ok     = (acc == rx_chk);
  assign fail_inc   = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;
  assign tmo_nxt    = tmo_cnt + 1'b1;
  // Fires on the idle edge where the counter would reach TIMEOUT-1;
  // an accepted bit always clears the counter, so the bit wins a tie.
  assign tmo_hit    = !take && (tmo_nxt == TMO_LAST);

  cas_key_chk #(.CHK_W(CHK_W), .IW(IW)) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start),
    .en     (take && (bit_cnt < KEY_END)),
    .bit_in (s_data),
    .idx    (IW'(bit_cnt % CHK_W)),
    .chk    (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    do_fail   = 1'b0;
    do_pass   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (load_start) begin
          state_nxt = ST_SHIFT;
          start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (take && (bit_cnt == LAST_BIT)) begin
          state_nxt = ST_CHECK;
        end else if (tmo_hit) begin
          do_fail   = 1'b1;
          state_nxt = (fail_inc == FAIL_MAX) ? ST_LOCKOUT : ST_ERROR;
        end
      end
      ST_CHECK: begin
        if (chk_ok) begin
          do_pass   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          do_fail   = 1'b1;
          state_nxt = (fail_inc == FAIL_MAX) ? ST_LOCKOUT : ST_ERROR;
        end
      end
      ST_LOCKOUT: state_nxt = ST_LOCKOUT;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      shadow      <= '0;
      rx_chk      <= '0;
      tmo_cnt     <= '0;
      keyinput    <= '0;
      key_valid   <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      fail_cnt    <= '0;
    end else begin
      if (start) begin
        bit_cnt     <= '0;
        shadow      <= '0;
        rx_chk      <= '0;
        tmo_cnt     <= '0;
        err_chk     <= 1'b0;
        err_timeout <= 1'b0;
        key_valid   <= 1'b0;
      end else if (take) begin
        bit_cnt <= bit_cnt + 1'b1;
        tmo_cnt <= '0;
        if (bit_cnt < KEY_END) shadow <= shadow | (KEY_W'(s_data) << bit_cnt);
        else                   rx_chk <= rx_chk | (CHK_W'(s_data) << (bit_cnt - KEY_END));
      end else if (state == ST_SHIFT) begin
        tmo_cnt <= tmo_nxt;
      end

      if (do_pass) begin
        keyinput  <= shadow;
        key_valid <= 1'b1;
        fail_cnt  <= '0;
      end
      if (do_fail) begin
        keyinput    <= '0;
        key_valid   <= 1'b0;
        fail_cnt    <= fail_inc;
        err_chk     <= (state == ST_CHECK);
        err_timeout <= (state == ST_SHIFT);
      end
    end
  end

endmodule

// File: tb/tb_cas_key_loader.sv
// Self-checking bench for cas_key_loader against a key/checksum reference model.
// Latency: n/a (testbench).
// Backpressure: serial driver waits on s_ready with a bounded budget.
module tb_cas_key_loader;

  localparam int KW = 64;
  localparam int CW = 8;
  localparam int MF = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_data = 1'b0;
  logic          s_ready;
  logic [KW-1:0] keyinput;
  logic          key_valid, busy, err_chk, err_timeout, locked_out;
  logic [1:0]    fail_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the externally visible result of each load.
  logic [KW-1:0] m_key;
  logic          m_kv, m_echk, m_etmo, m_lock;
  int            m_fail;

  wire [7:0] st = {key_valid, busy, s_ready, err_chk, err_timeout, locked_out, fail_cnt};

  cas_key_loader #(.KEY_W(KW), .CHK_W(CW), .MAX_FAIL(MF), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .keyinput(keyinput), .key_valid(key_valid), .busy(busy),
    .err_chk(err_chk), .err_timeout(err_timeout), .locked_out(locked_out), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] exp_st();
    return {m_kv, 1'b0, 1'b0, m_echk, m_etmo, m_lock, 2'(m_fail)};
  endfunction

  // Checksum = XOR of the key's CW-bit chunks.
  function automatic logic [CW-1:0] ref_chk(input logic [KW-1:0] key);
    logic [CW-1:0] r = '0;
    for (int c = 0; c < KW / CW; c++) r ^= key[c*CW +: CW];
    return r;
  endfunction

  task automatic model_reset();
    m_key = '0; m_kv = 0; m_echk = 0; m_etmo = 0; m_lock = 0; m_fail = 0;
  endtask

  task automatic model_fail(input logic is_tmo);
    m_key  = '0;
    m_kv   = 0;
    m_echk = !is_tmo;
    m_etmo = is_tmo;
    if (m_fail < MF) m_fail++;
    if (m_fail == MF) m_lock = 1;
  endtask

  task automatic model_load(input logic [KW-1:0] key, input logic [CW-1:0] chk);
    if (chk == ref_chk(key)) begin
      m_key = key; m_kv = 1; m_fail = 0; m_echk = 0; m_etmo = 0;
    end else begin
      model_fail(1'b0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid    = 0;
    load_start = 0;
    rst_n      = 0;
    #7;
    rst_n = 1;
    step();
    model_reset();
  endtask

  task automatic pulse_start();
    load_start = 1;
    step();
    load_start = 0;
  endtask

  // Sends frame bits [first, last) with up to gap_max idle cycles before each bit.
  task automatic send_frame(input logic [KW-1:0] key, input logic [CW-1:0] chk,
                            input int first, input int last, input int gap_max);
    logic [KW+CW-1:0] frame;
    frame = {chk, key};
    for (int k = first; k < last; k++) begin
      int g;
      int w;
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      s_valid = 0;
      repeat (g) step();
      s_valid = 1;
      s_data  = frame[k];
      w = 0;
      while (!s_ready && w < 40) begin
        step();
        w++;
      end
      if (!s_ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL s_ready_wait: bit %0d never accepted (s_ready=%b, want 1)", k, s_ready);
      end
      step();
    end
    s_valid = 0;
  endtask

  // Full frame then one edge for CHECK; returns just after the result edge.
  task automatic full_load(input logic [KW-1:0] key, input logic [CW-1:0] chk, input int gap_max);
    pulse_start();
    send_frame(key, chk, 0, KW + CW, gap_max);
    step();
    model_load(key, chk);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (st !== 8'h00) begin
      n_fail++; $display("FAIL reset_status: got %b want %b", st, 8'h00);
    end
    n_tests++;
    if (keyinput !== '0) begin
      n_fail++; $display("FAIL reset_key: got %h want 0", keyinput);
    end
  endtask

  task automatic test_good_load();
    logic [KW-1:0] k;
    k = 64'h0123456789ABCDEF;
    do_reset();
    pulse_start();
    send_frame(k, 8'h00, 0, KW + CW, 0);
    n_tests++;
    if ({busy, key_valid} !== 2'b10) begin
      n_fail++; $display("FAIL good_check_cycle: busy,key_valid got %b want 10", {busy, key_valid});
    end
    step();
    model_load(k, 8'h00);
    n_tests++;
    if (keyinput !== m_key) begin
      n_fail++; $display("FAIL good_key: got %h want %h", keyinput, m_key);
    end
    n_tests++;
    if (st !== exp_st()) begin
      n_fail++; $display("FAIL good_status: got %b want %b", st, exp_st());
    end
  endtask

  task automatic test_bad_chk();
    do_reset();
    full_load(64'h0123456789ABCDEF, 8'h01, 0);
    n_tests++;
    if (keyinput !== '0) begin
      n_fail++; $display("FAIL badchk_key: got %h want 0", keyinput);
    end
    n_tests++;
    if (st !== exp_st()) begin
      n_fail++; $display("FAIL badchk_status: got %b want %b", st, exp_st());
    end
  endtask

  task automatic test_timeout();
    logic [KW-1:0] k;
    do_reset();
    k = {$urandom, $urandom};
    pulse_start();
    send_frame(k, ref_chk(k), 0, 10, 0);
    repeat (TO - 2) step();
    n_tests++;
    if ({busy, err_timeout} !== 2'b10) begin
      n_fail++; $display("FAIL tmo_early: busy,err_timeout got %b want 10", {busy, err_timeout});
    end
    step();
    model_fail(1'b1);
    n_tests++;
    if (st !== exp_st()) begin
      n_fail++; $display("FAIL tmo_status: got %b want %b", st, exp_st());
    end
    k = {$urandom, $urandom};
    full_load(k, ref_chk(k), 0);
    n_tests++;
    if (keyinput !== m_key || st !== exp_st()) begin
      n_fail++; $display("FAIL tmo_recover: key %h st %b want key %h st %b", keyinput, st, m_key, exp_st());
    end
  endtask

  task automatic test_lockout();
    logic [KW-1:0] k;
    do_reset();
    for (int i = 0; i < MF; i++) begin
      k = {$urandom, $urandom};
      full_load(k, ref_chk(k) ^ 8'h5A, 0);
    end
    n_tests++;
    if (st !== exp_st() || keyinput !== '0) begin
      n_fail++; $display("FAIL lockout_status: st %b key %h want st %b key 0", st, keyinput, exp_st());
    end
    s_valid = 1;
    s_data  = 1;
    pulse_start();
    repeat (3) step();
    n_tests++;
    if ({s_ready, busy, locked_out} !== 3'b001) begin
      n_fail++; $display("FAIL lockout_sticky: s_ready,busy,locked got %b want 001", {s_ready, busy, locked_out});
    end
    do_reset();
    n_tests++;
    if (st !== 8'h00 || keyinput !== '0) begin
      n_fail++; $display("FAIL lockout_reset: st %b key %h want 0", st, keyinput);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [KW-1:0] k;
    do_reset();
    pulse_start();
    send_frame({KW{1'b1}}, 8'h00, 0, 30, 0);
    s_valid = 1;
    s_data  = 1;
    rst_n   = 0;
    #3;
    s_valid = 0;
    #4;
    rst_n = 1;
    step();
    model_reset();
    k = 64'hFFFFFFFF00000000;
    full_load(k, 8'h00, 0);
    n_tests++;
    if (keyinput !== m_key || st !== exp_st()) begin
      n_fail++; $display("FAIL midreset_load: key %h st %b want key %h st %b", keyinput, st, m_key, exp_st());
    end
  endtask

  task automatic test_ignore();
    logic [KW-1:0] k;
    do_reset();
    k = {$urandom, $urandom};
    s_valid = 1;
    s_data  = 1;
    repeat (4) step();
    n_tests++;
    if (s_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_ready: got %b want 0", s_ready);
    end
    pulse_start();
    send_frame(k, ref_chk(k), 0, 20, 0);
    pulse_start();
    send_frame(k, ref_chk(k), 20, KW + CW, 0);
    step();
    model_load(k, ref_chk(k));
    n_tests++;
    if (keyinput !== m_key || st !== exp_st()) begin
      n_fail++; $display("FAIL ignore_start: key %h st %b want key %h st %b", keyinput, st, m_key, exp_st());
    end
  endtask

  task automatic test_random();
    logic [KW-1:0] k;
    logic [CW-1:0] c;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      k = {$urandom, $urandom};
      c = ref_chk(k);
      if ($urandom_range(0, 2) == 0) c ^= 8'($urandom_range(1, 255));
      full_load(k, c, 3);
      n_tests++;
      if (keyinput !== m_key || st !== exp_st()) begin
        n_fail++; $display("FAIL random_load %0d: key %h st %b want key %h st %b", i, keyinput, st, m_key, exp_st());
      end
      if (m_lock) do_reset();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_good_load();
    test_bad_chk();
    test_timeout();
    test_lockout();
    test_reset_mid_shift();
    test_ignore();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
